// File: rtl/axi_mem_arbiter_if.sv
// rtl/axi_mem_arbiter_if.sv - read and write channel bundles used by axi_mem_arbiter
interface axi_rd_if;
  logic        arvalid;
  logic [31:0] araddr;
  logic        rready;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;

  modport master (output arvalid, araddr, rready, input arready, rdata, rvalid, rlast);
  modport slave  (input arvalid, araddr, rready, output arready, rdata, rvalid, rlast);
endinterface

interface axi_wr_if;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bready;
  logic        awready;
  logic        wready;
  logic        bvalid;

  modport master (output awvalid, awaddr, wvalid, wdata, wstrb, bready,
                  input awready, wready, bvalid);
  modport slave  (input awvalid, awaddr, wvalid, wdata, wstrb, bready,
                  output awready, wready, bvalid);
endinterface

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - IFU/LSU to single memory AXI arbiter, one read and one write in flight
module axi_mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic      clock,
  input logic      reset,
  axi_rd_if.slave  ifu_r,
  axi_rd_if.slave  lsu_r,
  axi_wr_if.slave  lsu_w,
  axi_rd_if.master mem_r,
  axi_wr_if.master mem_w
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  r_state_t    r_state;
  logic        r_owner;
  logic        last_grant;
  logic        mem_arvalid_q;
  logic [31:0] r_addr_q;

  w_state_t    w_state;
  logic        mem_awvalid_q;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic w_accept;
  logic ifu_req;
  logic lsu_req;
  logic grant_lsu;
  logic ifu_grant;
  logic lsu_grant;
  logic r_data_ifu;
  logic r_data_lsu;
  logic mem_rready;

  // A write accepted this cycle blocks the LSU read so the store reaches memory first.
  always_comb begin
    w_accept = (w_state == W_IDLE) && lsu_w.awvalid && lsu_w.wvalid;
    ifu_req  = (r_state == R_IDLE) && ifu_r.arvalid;
    lsu_req  = (r_state == R_IDLE) && lsu_r.arvalid && (w_state == W_IDLE) && !w_accept;
    if (ifu_req && lsu_req) begin
      grant_lsu = RR_EN ? (last_grant == OWN_IFU) : 1'b1;
    end else begin
      grant_lsu = lsu_req;
    end
    ifu_grant = ifu_req && !grant_lsu;
    lsu_grant = lsu_req && grant_lsu;
  end

  always_comb begin
    r_data_ifu = (r_state == R_DATA) && (r_owner == OWN_IFU);
    r_data_lsu = (r_state == R_DATA) && (r_owner == OWN_LSU);
    mem_rready = 1'b0;
    if (r_data_ifu) begin
      mem_rready = ifu_r.rready;
    end else if (r_data_lsu) begin
      mem_rready = lsu_r.rready;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= R_IDLE;
      r_owner       <= OWN_IFU;
      last_grant    <= OWN_LSU;
      mem_arvalid_q <= 1'b0;
      r_addr_q      <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ifu_grant || lsu_grant) begin
            r_owner       <= lsu_grant;
            last_grant    <= lsu_grant;
            r_addr_q      <= lsu_grant ? lsu_r.araddr : ifu_r.araddr;
            mem_arvalid_q <= 1'b1;
            r_state       <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (mem_r.arready) begin
            mem_arvalid_q <= 1'b0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (mem_r.rvalid && mem_rready && mem_r.rlast) begin
            r_state <= R_IDLE;
          end
        end
        default: begin
          mem_arvalid_q <= 1'b0;
          r_state       <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state       <= W_IDLE;
      mem_awvalid_q <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (w_accept) begin
            aw_addr_q     <= lsu_w.awaddr;
            w_data_q      <= lsu_w.wdata;
            w_strb_q      <= lsu_w.wstrb;
            mem_awvalid_q <= 1'b1;
            w_state       <= W_REQ;
          end
        end
        W_REQ: begin
          if (mem_w.awready && mem_w.wready) begin
            mem_awvalid_q <= 1'b0;
            w_state       <= W_RESP;
          end
        end
        W_RESP: begin
          if (mem_w.bvalid && lsu_w.bready) begin
            w_state <= W_IDLE;
          end
        end
        default: begin
          mem_awvalid_q <= 1'b0;
          w_state       <= W_IDLE;
        end
      endcase
    end
  end

  assign ifu_r.arready = ifu_grant;
  assign ifu_r.rvalid  = r_data_ifu && mem_r.rvalid;
  assign ifu_r.rdata   = mem_r.rdata;
  assign ifu_r.rlast   = r_data_ifu && mem_r.rlast;

  assign lsu_r.arready = lsu_grant;
  assign lsu_r.rvalid  = r_data_lsu && mem_r.rvalid;
  assign lsu_r.rdata   = mem_r.rdata;
  assign lsu_r.rlast   = r_data_lsu && mem_r.rlast;

  assign mem_r.arvalid = mem_arvalid_q;
  assign mem_r.araddr  = r_addr_q;
  assign mem_r.rready  = mem_rready;

  // AW and W always travel together, so one register drives both valids.
  assign lsu_w.awready = w_accept;
  assign lsu_w.wready  = w_accept;
  assign lsu_w.bvalid  = (w_state == W_RESP) && mem_w.bvalid;

  assign mem_w.awvalid = mem_awvalid_q;
  assign mem_w.wvalid  = mem_awvalid_q;
  assign mem_w.awaddr  = aw_addr_q;
  assign mem_w.wdata   = w_data_q;
  assign mem_w.wstrb   = w_strb_q;
  assign mem_w.bready  = (w_state == W_RESP) && lsu_w.bready;
endmodule
